fila_entrada: RTL and testbench
===============================

// Module: fila_entrada
// PURPOSE
// - Input stage directly upstream of the 8-entry byte queue, in the 10 kHz clock domain.
// - Turns two raw push-buttons (enqueue, dequeue) and 8 data switches into clean
//   single-cycle enqueue/dequeue command pulses, with the data byte held stable.
// - Uses the queue's length feedback to refuse an enqueue when full or a dequeue when empty.
// PARAMETERS
// - DEBOUNCE_CYCLES  200  consecutive stable cycles required for press/release (20 ms @ 10 kHz); min 2
// - DEPTH            8    queue capacity; enqueue allowed only while len_in < DEPTH
// - DATA_W           8    width of switches_in / data_out
// PORTS
// - clock_10KHz  in   1       only clock; all logic on posedge
// - reset        in   1       synchronous, active-high
// - btn_enq_in   in   1       raw enqueue button, async, active-high
// - btn_deq_in   in   1       raw dequeue button, async, active-high
// - switches_in  in   DATA_W  raw data switches, async
// - len_in       in   8       current queue occupancy (queue len_out)
// - enqueue_out  out  1       one-cycle enqueue command (drives queue enqueue_in)
// - dequeue_out  out  1       one-cycle dequeue command (drives queue dequeue_in)
// - data_out     out  DATA_W  byte to enqueue (drives queue data_in)
// - busy_out     out  1       1 whenever state != IDLE
// - reject_out   out  1       one-cycle pulse: press refused (see CONFIGURATION)
// BEHAVIOUR
// - Reset (sync, takes effect on the next edge, also mid-operation): state=IDLE, counter=0,
//   sync flops=0. Outputs: enqueue_out=0, dequeue_out=0, data_out=0, busy_out=0, reject_out=0.
// - Inputs btn_enq_in, btn_deq_in and switches_in pass through a 2-flop synchronizer.
//   Everything below uses the synced values (enq_s, deq_s, sw_s).
// - All outputs are registered.
// - FSM:
//   - IDLE: exactly one of enq_s/deq_s high -> record which (cmd), counter=0, go to DEBOUNCE.
//     Both high, or none -> stay.
//   - DEBOUNCE: counter++ each cycle while the recorded button stays high and the other stays low.
//     Any violation -> IDLE.
//     counter == DEBOUNCE_CYCLES-1 -> FIRE.
//   - FIRE (1 cycle), decided on the entry edge:
//     - ENQ with len_in < DEPTH: enqueue_out=1 and data_out=sw_s.
//     - DEQ with len_in != 0: dequeue_out=1.
//     - Otherwise: no command; reject_out=1 if REJECT enabled.
//     - Next state is RELEASE, counter=0.
//   - RELEASE: counter++ while both buttons are low; any high -> counter=0.
//     counter == DEBOUNCE_CYCLES-1 -> IDLE.
// - A held button yields exactly one command; auto-repeat never occurs.
// - data_out holds its value after the pulse until the next accepted enqueue; it changes only in FIRE.
// - enqueue_out and dequeue_out are never high in the same cycle.
//   Both are always 0 outside the cycle after FIRE entry.
// - len_in is sampled only at FIRE entry. The downstream queue consumes a pulse within 1 cycle.
//   Its length updates before the next possible FIRE, because the minimum spacing is
//   2*DEBOUNCE_CYCLES cycles.
// - Latency: a clean press at the pin produces its pulse 2 (sync) + DEBOUNCE_CYCLES + 1 cycles later.
// - len_in > DEPTH is treated as full.
// CONFIGURATION
// - Macro FILA_ENTRADA_REJECT_EN:
//   - Defined: reject_out pulses 1 cycle in the refused-FIRE case (enq when full, deq when empty).
//   - Undefined: reject_out is tied to 0 and no reject logic is built.
//   - Command behaviour is identical either way.
// TESTING (bench: DEBOUNCE_CYCLES=4, DEPTH=8)
// - Reset mid-DEBOUNCE -> next cycle all outputs 0, busy_out=0.
//   A new press still needs the full 4 stable cycles.
// - btn_enq_in held 20 cycles, switches_in=8'hA5, len_in=3 -> exactly one enqueue_out pulse,
//   7 cycles after the press; data_out=8'hA5 and held afterwards.
// - btn_enq_in bouncing 1,0,1,0 every cycle, then low -> no pulse, FSM returns to IDLE.
// - btn_deq_in press with len_in=0 -> no dequeue_out.
//   reject_out=1 for 1 cycle with the macro defined, 0 without it.
// - btn_enq_in press with len_in=8 -> no enqueue_out, data_out unchanged.
// - Both buttons pressed together -> no command.
//   Enq press, release 2 cycles, press again -> second press ignored until 4 low cycles have passed.

Source files
------------

// File: rtl/fila_entrada.sv
// fila_entrada: debounced push-button front end issuing single enqueue/dequeue pulses to the byte queue.
// Define FILA_ENTRADA_REJECT_EN to build the reject_out pulse for refused presses.
module fila_entrada #(
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int DEPTH = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock_10KHz,
  input  logic              reset,
  input  logic              btn_enq_in,
  input  logic              btn_deq_in,
  input  logic [DATA_W-1:0] switches_in,
  input  logic [7:0]        len_in,
  output logic              enqueue_out,
  output logic              dequeue_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy_out,
  output logic              reject_out
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, FIRE, RELEASE} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              cmd_q, enq_q, deq_q, busy_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W+1:0] s1_q, s2_q;
  logic              enq_s, deq_s, held, last, can_enq, can_deq;
  logic [DATA_W-1:0] sw_s;
  always_ff @(posedge clock_10KHz) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {btn_enq_in, btn_deq_in, switches_in};
      s2_q <= s1_q;
    end
  end
  assign enq_s   = s2_q[DATA_W+1];
  assign deq_s   = s2_q[DATA_W];
  assign sw_s    = s2_q[DATA_W-1:0];
  assign held    = cmd_q ? (enq_s & ~deq_s) : (deq_s & ~enq_s);
  assign last    = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  assign can_enq = 32'(len_in) < DEPTH;
  assign can_deq = len_in != 8'd0;
  // Command and data are decided on the edge that enters FIRE, so the pulse is registered.
  always_ff @(posedge clock_10KHz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= 1'b0;
      enq_q   <= 1'b0;
      deq_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      enq_q <= 1'b0;
      deq_q <= 1'b0;
      case (state_q)
        IDLE: if (enq_s ^ deq_s) begin
          cmd_q   <= enq_s;
          cnt_q   <= '0;
          state_q <= DEBOUNCE;
          busy_q  <= 1'b1;
        end
        DEBOUNCE: if (!held) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (last) begin
          state_q <= FIRE;
          enq_q   <= cmd_q & can_enq;
          deq_q   <= ~cmd_q & can_deq;
          if (cmd_q && can_enq) data_q <= sw_s;
        end else cnt_q <= cnt_q + CW'(1);
        FIRE: begin
          state_q <= RELEASE;
          cnt_q   <= '0;
        end
        RELEASE: if (enq_s || deq_s) cnt_q <= '0;
        else if (last) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else cnt_q <= cnt_q + CW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
  assign enqueue_out = enq_q;
  assign dequeue_out = deq_q;
  assign data_out    = data_q;
  assign busy_out    = busy_q;
`ifdef FILA_ENTRADA_REJECT_EN
  logic rej_q;
  always_ff @(posedge clock_10KHz) begin
    if (reset) rej_q <= 1'b0;
    else rej_q <= state_q == DEBOUNCE && held && last && !(cmd_q ? can_enq : can_deq);
  end
  assign reject_out = rej_q;
`else
  assign reject_out = 1'b0;
`endif
endmodule

// File: tb/tb_fila_entrada.sv
// tb_fila_entrada: directed checks of debounce timing, single-pulse commands and full/empty refusal.
module tb_fila_entrada;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_enq = 1'b0, btn_deq = 1'b0;
  logic [7:0] sw = 8'h00, len = 8'd0;
  logic       enq_o, deq_o, busy_o, rej_o;
  logic [7:0] data_o;
  int         checks = 0, errors = 0;
  logic       rej_en;

  fila_entrada #(.DEBOUNCE_CYCLES(4), .DEPTH(8), .DATA_W(8)) dut (
    .clock_10KHz(clk), .reset(reset), .btn_enq_in(btn_enq), .btn_deq_in(btn_deq),
    .switches_in(sw), .len_in(len), .enqueue_out(enq_o), .dequeue_out(deq_o),
    .data_out(data_o), .busy_out(busy_o), .reject_out(rej_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) step();
    chk("idle_after_release", 32'(busy_o), 32'd0);
  endtask

  initial begin
`ifdef FILA_ENTRADA_REJECT_EN
    rej_en = 1'b1;
`else
    rej_en = 1'b0;
`endif
    step();
    step();
    chk("rst_enq", 32'(enq_o), 32'd0);
    chk("rst_deq", 32'(deq_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rej", 32'(rej_o), 32'd0);
    reset = 1'b0;
    step();
    // held enqueue: one pulse at cycle 7, data latched
    sw = 8'hA5; len = 8'd3; btn_enq = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("hold_enq_pulse", 32'(enq_o), 32'(i == 7));
      chk("hold_deq_zero", 32'(deq_o), 32'd0);
      if (i == 2) chk("hold_busy_c2", 32'(busy_o), 32'd0);
      if (i == 3) chk("hold_busy_c3", 32'(busy_o), 32'd1);
      if (i == 6) chk("hold_data_pre", 32'(data_o), 32'h00);
      if (i == 20) btn_enq = 1'b0;
    end
    chk("hold_data", 32'(data_o), 32'hA5);
    chk("hold_idle", 32'(busy_o), 32'd0);
    sw = 8'h3C;
    step();
    step();
    step();
    chk("data_held", 32'(data_o), 32'hA5);
    // reset in the middle of debounce restarts everything
    len = 8'd4; btn_enq = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy_pre", 32'(busy_o), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_enq", 32'(enq_o), 32'd0);
    chk("mid_rst_data", 32'(data_o), 32'd0);
    chk("mid_rst_rej", 32'(rej_o), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("post_rst_enq", 32'(enq_o), 32'(i == 7));
      if (i == 2) chk("post_rst_busy_c2", 32'(busy_o), 32'd0);
    end
    btn_enq = 1'b0;
    chk("post_rst_data", 32'(data_o), 32'h3C);
    wait_idle();
    // bouncing button never fires
    for (int i = 0; i < 4; i++) begin
      btn_enq = (i % 2 == 0);
      step();
      chk("bounce_enq", 32'(enq_o), 32'd0);
    end
    btn_enq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bounce_enq_tail", 32'(enq_o), 32'd0);
    end
    chk("bounce_idle", 32'(busy_o), 32'd0);
    // dequeue on empty queue is refused
    len = 8'd0; btn_deq = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("deq_empty_deq", 32'(deq_o), 32'd0);
      chk("deq_empty_rej", 32'(rej_o), 32'(rej_en && i == 7));
    end
    btn_deq = 1'b0;
    wait_idle();
    // dequeue with data present
    len = 8'd5; btn_deq = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("deq_ok_deq", 32'(deq_o), 32'(i == 7));
      chk("deq_ok_enq", 32'(enq_o), 32'd0);
      chk("deq_ok_rej", 32'(rej_o), 32'd0);
    end
    btn_deq = 1'b0;
    chk("deq_ok_data", 32'(data_o), 32'h3C);
    wait_idle();
    // enqueue on full queue: no pulse, data unchanged
    len = 8'd8; sw = 8'hFF; btn_enq = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("enq_full_enq", 32'(enq_o), 32'd0);
      chk("enq_full_rej", 32'(rej_o), 32'(rej_en && i == 7));
    end
    btn_enq = 1'b0;
    chk("enq_full_data", 32'(data_o), 32'h3C);
    wait_idle();
    // length above DEPTH counts as full
    len = 8'd200; btn_enq = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("enq_over_enq", 32'(enq_o), 32'd0);
    end
    btn_enq = 1'b0;
    chk("enq_over_data", 32'(data_o), 32'h3C);
    wait_idle();
    // both buttons together: stay idle
    len = 8'd2; btn_enq = 1'b1; btn_deq = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("both_cmd", 32'({enq_o, deq_o}), 32'd0);
      chk("both_busy", 32'(busy_o), 32'd0);
    end
    btn_enq = 1'b0; btn_deq = 1'b0;
    step();
    step();
    step();
    // short release then re-press is ignored until 4 low cycles pass
    len = 8'd1; sw = 8'h11; btn_enq = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("repress_enq", 32'(enq_o), 32'(i == 7));
      if (i == 8) btn_enq = 1'b0;
      if (i == 10) begin
        btn_enq = 1'b1;
        sw = 8'h22;
      end
      if (i == 20) btn_enq = 1'b0;
      if (i == 25) chk("repress_busy_c25", 32'(busy_o), 32'd1);
      if (i == 26) chk("repress_busy_c26", 32'(busy_o), 32'd0);
    end
    chk("repress_data", 32'(data_o), 32'h11);
    btn_enq = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("second_enq", 32'(enq_o), 32'(i == 7));
    end
    btn_enq = 1'b0;
    chk("second_data", 32'(data_o), 32'h22);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
